path_sequencer: RTL
===================

PATH_SEQUENCER -- requirements
Module: path_sequencer

Interface
REQ-001 SHALL have parameter THR_NODE, default 1000, meaning node threshold; a sensor is node-dark when its reading is > THR_NODE.
REQ-002 SHALL have parameter THR_BLK, default 500, meaning line-black threshold (> THR_BLK).
REQ-003 SHALL have parameter THR_WHT, default 200, meaning line-white threshold (< THR_WHT).
REQ-004 SHALL have parameter NODE_CONFIRM, default 3, meaning consecutive node-dark samples required to declare a node.
REQ-005 SHALL have parameter TURN_TIMEOUT, default 255, meaning maximum samples spent in one turn phase.
REQ-006 SHALL have port clk_50M, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: begin route, level-sampled in IDLE only.
REQ-009 SHALL have ports left, middle and right, input, 12 bits each: LFA ADC readings.
REQ-010 SHALL have port sample_valid, input, 1 bit: one-cycle pulse that marks left/middle/right as a new coherent sample.
REQ-011 SHALL have port cmd_data, input, 2 bits: route command, 00 straight, 01 left, 10 right, 11 end.
REQ-012 SHALL have ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit): valid/ready handshake for cmd_data.
REQ-013 SHALL have ports m1_a, m1_b, m2_a and m2_b, output, 1 bit each: motor direction (m1 = left motor, m2 = right motor; x_a=1/x_b=0 is forward, x_a=0/x_b=1 is reverse, 0/0 is stop).
REQ-014 SHALL have ports dc1 and dc2, output, 4 bits each: left and right PWM duty (0..15).
REQ-015 SHALL have port node_count, output, 8 bits: number of confirmed nodes.
REQ-016 SHALL have port node_pulse, output, 1 bit: one-cycle pulse on each node confirmation.
REQ-017 SHALL have ports busy, done and fault, output, 1 bit each: status.

Function
REQ-018 SHALL implement states IDLE, FOLLOW, NODE_CHK, FETCH, CROSS, TURN_EXIT, TURN_ACQ, DONE and FAULT.
REQ-019 SHALL evaluate sensor-dependent transitions and steering only on cycles where sample_valid=1; all outputs SHALL be registered and update on the clock edge after the qualifying sample.
REQ-020 IDLE: motors stop, dc 0/0; start=1 -> FOLLOW, node_count cleared to 0.
REQ-021 FOLLOW steering, first match wins:
- right>THR_BLK && left<THR_WHT -> m1 forward, m2 reverse, dc 8/3.
- left>THR_BLK && right<THR_WHT -> m1 reverse, m2 forward, dc 3/8.
- left<THR_WHT && middle>THR_BLK && right<THR_WHT -> both forward, dc 8/8.
- otherwise hold the previous drive.
REQ-022 FOLLOW: all three node-dark -> NODE_CHK with confirm counter = 1; the drive is held.
REQ-023 NODE_CHK: each node-dark sample increments the counter; reaching NODE_CONFIRM -> FETCH, node_count+1 (wraps 255->0), node_pulse=1; any non-node sample -> FOLLOW with the counter cleared.
REQ-024 FETCH: motors stop, dc 0/0, cmd_ready=1; waits indefinitely while cmd_valid=0; a transfer (cmd_valid&&cmd_ready) deasserts cmd_ready the next cycle and dispatches:
- 00 -> CROSS.
- 01 or 10 -> TURN_EXIT.
- 11 -> DONE.
REQ-025 cmd_ready SHALL be 0 in every state other than FETCH.
REQ-026 CROSS: both forward, dc 8/8; first sample that is not all node-dark -> FOLLOW.
REQ-027 TURN_EXIT: left turn = m1 reverse, m2 forward, dc 6/6; right turn = mirror; middle<THR_WHT -> TURN_ACQ.
REQ-028 TURN_ACQ: same drive as TURN_EXIT; middle>THR_BLK -> FOLLOW.
REQ-029 A phase sample counter SHALL clear on entry to each of TURN_EXIT and TURN_ACQ and count samples; reaching TURN_TIMEOUT -> FAULT.
REQ-030 DONE: motors stop, done=1 until reset or start; start=1 -> FOLLOW with node_count cleared.
REQ-031 FAULT: motors stop, fault=1, sticky until reset.
REQ-032 busy SHALL be 1 in every state except IDLE, DONE and FAULT.
REQ-033 start SHALL be ignored when the state is not IDLE or DONE.
REQ-034 If sample_valid coincides with a FETCH handshake, the handshake SHALL take priority and the sample SHALL be discarded.

Reset
REQ-035 While reset_n=0, the block SHALL be in IDLE and every output SHALL be 0 (m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_count, node_pulse, cmd_ready, busy, done, fault); all counters SHALL be cleared.
REQ-036 Assertion of reset_n=0 mid-turn or mid-FETCH SHALL stop the motors asynchronously and discard any pending command; no command SHALL be consumed during reset.

Verification
REQ-037 Straight line: start, samples (100,800,100) -> both forward, dc 8/8, busy=1, node_count=0.
REQ-038 Node debounce: samples of 1100/1100/1100 ×2 then (100,800,100) -> no node_pulse, state FOLLOW; the same readings ×3 -> node_pulse once, node_count=1, cmd_ready=1, motors stop.
REQ-039 Left turn: cmd 01 accepted, middle=100 then middle=800 -> m1 reverse, m2 forward, dc 6/6 through both phases, then FOLLOW.
REQ-040 Backpressure: hold cmd_valid=0 for 50 cycles in FETCH -> cmd_ready stays 1, motors stop; cmd 11 -> done=1, busy=0.
REQ-041 Timeout: right turn with middle held at 800 for 255 samples -> fault=1, motors stop; a later start is ignored.
REQ-042 Reset mid-turn: reset_n=0 during TURN_ACQ -> all outputs 0 immediately; after release, IDLE with node_count=0.

Source files
------------

// File: rtl/path_sequencer_if.sv
// Route-command channel for path_sequencer.
//   cmd_data  : 2-bit route command (00 straight, 01 left, 10 right, 11 end)
//   cmd_valid : producer has a command on cmd_data
//   cmd_ready : sequencer can take a command this cycle
// A command transfers on a cycle where cmd_valid && cmd_ready.
interface path_sequencer_if;
  logic [1:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_data, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/path_sequencer.sv
// Line-follower route sequencer. Follows a line with a 3-sensor LFA, counts
// debounced nodes (all three sensors dark), and at each node fetches a route
// command that selects crossing straight, turning left/right, or finishing.
// Ports:
//   clk_50M, reset_n        : clock (rising edge) and async active-low reset
//   start                   : begin route (honoured in IDLE and DONE only)
//   left/middle/right       : 12-bit sensor readings, qualified by sample_valid
//   cmd                     : route-command valid/ready channel (slave side)
//   m1_a/m1_b, m2_a/m2_b    : left/right motor direction (a=fwd, b=rev)
//   dc1, dc2                : left/right PWM duty 0..15
//   node_count, node_pulse  : confirmed node count and one-cycle strobe
//   busy, done, fault       : status
// All outputs are registered.
module path_sequencer #(
  parameter int unsigned THR_NODE     = 1000,
  parameter int unsigned THR_BLK      = 500,
  parameter int unsigned THR_WHT      = 200,
  parameter int unsigned NODE_CONFIRM = 3,
  parameter int unsigned TURN_TIMEOUT = 255
) (
  input  logic              clk_50M,
  input  logic              reset_n,
  input  logic              start,
  input  logic [11:0]       left,
  input  logic [11:0]       middle,
  input  logic [11:0]       right,
  input  logic              sample_valid,
  path_sequencer_if.slave   cmd,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [3:0]        dc1,
  output logic [3:0]        dc2,
  output logic [7:0]        node_count,
  output logic              node_pulse,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam logic [11:0] NODE_L = 12'(THR_NODE);
  localparam logic [11:0] BLK_L  = 12'(THR_BLK);
  localparam logic [11:0] WHT_L  = 12'(THR_WHT);
  localparam int unsigned CW     = $clog2(NODE_CONFIRM + 1);
  localparam int unsigned PW     = $clog2(TURN_TIMEOUT + 1);
  localparam logic [CW:0] CONF_LIM  = (CW + 1)'(NODE_CONFIRM);
  localparam logic [PW:0] PHASE_LIM = (PW + 1)'(TURN_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, FOLLOW, NODE_CHK, FETCH, CROSS, TURN_EXIT, TURN_ACQ, DONE, FAULT
  } state_t;

  typedef struct packed {
    logic       m1_a;
    logic       m1_b;
    logic       m2_a;
    logic       m2_b;
    logic [3:0] dc1;
    logic [3:0] dc2;
  } drive_t;

  localparam drive_t DRV_STOP  = '0;
  localparam drive_t DRV_FWD   = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8};
  localparam drive_t DRV_STR_R = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd3};
  localparam drive_t DRV_STR_L = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd8};
  localparam drive_t DRV_TRN_L = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 4'd6};
  localparam drive_t DRV_TRN_R = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd6};

  state_t        state_q, state_d;
  drive_t        drive_q, drive_d;
  logic [7:0]    count_q, count_d;
  logic          pulse_q, pulse_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          turn_right_q, turn_right_d;

  logic          node_dark, l_blk, l_wht, m_blk, m_wht, r_blk, r_wht;
  logic          handshake, conf_hit, phase_hit;

  assign node_dark = (left > NODE_L) && (middle > NODE_L) && (right > NODE_L);
  assign l_blk     = left > BLK_L;
  assign l_wht     = left < WHT_L;
  assign m_blk     = middle > BLK_L;
  assign m_wht     = middle < WHT_L;
  assign r_blk     = right > BLK_L;
  assign r_wht     = right < WHT_L;
  assign handshake = cmd.cmd_valid && ready_q;
  assign conf_hit  = ({1'b0, conf_q} + 1'b1) >= CONF_LIM;
  assign phase_hit = ({1'b0, phase_q} + 1'b1) >= PHASE_LIM;

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state. FETCH ignores samples, so a coincident sample is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = FOLLOW;
      FOLLOW:     if (sample_valid && node_dark) state_d = NODE_CHK;
      NODE_CHK: if (sample_valid) begin
        if (!node_dark)    state_d = FOLLOW;
        else if (conf_hit) state_d = FETCH;
      end
      FETCH: if (handshake) begin
        case (cmd.cmd_data)
          2'b00:   state_d = CROSS;
          2'b11:   state_d = DONE;
          default: state_d = TURN_EXIT;
        endcase
      end
      CROSS:     if (sample_valid && !node_dark) state_d = FOLLOW;
      TURN_EXIT: if (sample_valid) begin
        if (m_wht)          state_d = TURN_ACQ;
        else if (phase_hit) state_d = FAULT;
      end
      TURN_ACQ: if (sample_valid) begin
        if (m_blk)          state_d = FOLLOW;
        else if (phase_hit) state_d = FAULT;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and counters are computed from the transition (state_q -> state_d)
  // so that every output lands in the register on the same edge as the state.
  always_comb begin
    drive_d      = drive_q;
    count_d      = count_q;
    pulse_d      = 1'b0;
    turn_right_d = turn_right_q;
    conf_d       = '0;
    phase_d      = '0;

    if (handshake) turn_right_d = (cmd.cmd_data == 2'b10);

    if (state_d == NODE_CHK)
      conf_d = (state_q == NODE_CHK) ? conf_q + CW'(sample_valid) : CW'(1);

    if (state_d == state_q && sample_valid &&
        (state_q == TURN_EXIT || state_q == TURN_ACQ))
      phase_d = phase_q + PW'(1);
    else if (state_d == state_q)
      phase_d = phase_q;

    if ((state_q == IDLE || state_q == DONE) && state_d == FOLLOW) begin
      count_d = '0;
    end else if (state_q == NODE_CHK && state_d == FETCH) begin
      count_d = count_q + 8'd1;
      pulse_d = 1'b1;
    end

    case (state_d)
      IDLE, FETCH, DONE, FAULT: drive_d = DRV_STOP;
      CROSS:                    drive_d = DRV_FWD;
      TURN_EXIT, TURN_ACQ:      drive_d = turn_right_d ? DRV_TRN_R : DRV_TRN_L;
      FOLLOW: if (state_q == FOLLOW && sample_valid) begin
        if (r_blk && l_wht)              drive_d = DRV_STR_R;
        else if (l_blk && r_wht)         drive_d = DRV_STR_L;
        else if (l_wht && m_blk && r_wht) drive_d = DRV_FWD;
      end
      default: ;
    endcase

    ready_d = (state_d == FETCH);
    done_d  = (state_d == DONE);
    fault_d = (state_d == FAULT);
    busy_d  = !(state_d == IDLE || state_d == DONE || state_d == FAULT);
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      drive_q      <= DRV_STOP;
      count_q      <= '0;
      pulse_q      <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      conf_q       <= '0;
      phase_q      <= '0;
      turn_right_q <= 1'b0;
    end else begin
      drive_q      <= drive_d;
      count_q      <= count_d;
      pulse_q      <= pulse_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      conf_q       <= conf_d;
      phase_q      <= phase_d;
      turn_right_q <= turn_right_d;
    end
  end

  assign m1_a          = drive_q.m1_a;
  assign m1_b          = drive_q.m1_b;
  assign m2_a          = drive_q.m2_a;
  assign m2_b          = drive_q.m2_b;
  assign dc1           = drive_q.dc1;
  assign dc2           = drive_q.dc2;
  assign node_count    = count_q;
  assign node_pulse    = pulse_q;
  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;

endmodule
